commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
Retire-side observation block that sits directly downstream of the CPU's commit point (PC, instruction, register write-back, data-memory access, halt).
- Classifies each retired instruction and assigns it a 0-based instruction number.
- Buffers the resulting records in a small FIFO drained over a valid/ready port.
- Keeps instruction/cycle counters and sequences halt into a clean drained-and-stopped state.
- Used by the phase-2 pipelined CPU bench and by on-board debug capture in place of per-cycle sampling.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >= 2
CNT_W, 32, width of inst_count, cycle_count, drop_count and the record inum field

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  one instruction retires this cycle (0 = bubble)
in_pc  in  16  PC of retiring instruction
in_inst  in  16  instruction word
in_regwrite  in  1  register file written
in_wreg  in  4  destination register
in_wdata  in  16  write-back data
in_memread  in  1  data memory read
in_memwrite  in  1  data memory write
in_memaddr  in  16  data memory address
in_memdata  in  16  store data
in_halt  in  1  retiring instruction is HLT
out_valid  out  1  FIFO head record valid
out_ready  in  1  consumer accepts head record
out_kind  out  3  0 OTHER (branch/NOP), 1 REG, 2 LOAD, 3 STORE, 4 HALT
out_inum  out  CNT_W  instruction number of the record
out_pc  out  16  record PC
out_reg  out  4  destination register (REG/LOAD), else 0
out_value  out  16  wdata (REG/LOAD), memdata (STORE), else 0
out_addr  out  16  memaddr (LOAD/STORE), else 0
inst_count  out  CNT_W  retired instructions
cycle_count  out  CNT_W  cycles spent in RUN or DRAIN
drop_count  out  CNT_W  records lost to a full FIFO
overflow  out  1  sticky: at least one record dropped
halted  out  1  HALTED state

Behaviour:
- Reset (rst_n=0 at posedge clk): state RUN; FIFO empty; all counters 0; overflow=0; halted=0; out_valid=0; out_* data=0.
- Retire event = in_valid & state==RUN. Inputs are ignored in DRAIN/HALTED.
- Kind priority:
  - in_halt -> HALT
  - else in_regwrite&in_memread -> LOAD
  - else in_regwrite -> REG
  - else in_memwrite -> STORE
  - else OTHER
- Fields not meaningful for the chosen kind are forced to 0.
- On a retire event:
  - inum = inst_count before the increment.
  - inst_count += 1.
  - The record is pushed if the FIFO is not full, or if it is full and a pop happens the same cycle.
  - Otherwise the record is dropped: drop_count += 1, overflow=1 (sticky until reset).
- Latency: a pushed record appears at out_valid the cycle after capture. There is no combinational bypass.
- Pop: out_valid & out_ready at posedge. out_* data holds stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on an empty FIFO: the pop is a no-op and the push succeeds.
- FSM:
  - RUN: on a HALT retire event -> DRAIN, even if the halt record itself was dropped.
  - DRAIN: when the FIFO is empty (including an empty-after-pop this cycle) -> HALTED next cycle.
  - HALTED: halted=1, out_valid=0; stays until reset.
- cycle_count increments each cycle in RUN or DRAIN, and is frozen in HALTED.
- All counters wrap modulo 2^CNT_W; overflow is not flagged by counter wrap.
- Reset mid-operation: all records are discarded, all counters are cleared, FSM returns to RUN.

Optional Feature:
TRACE_FILTER_EN
- Defined: adds input filter_mask[4:0], indexed by kind. A retire event whose filter_mask[kind]=0 is counted (inst_count, inum consumed) but not pushed, and never causes a drop.
- HALT records always obey the mask, but the FSM transition to DRAIN happens regardless.
- Undefined: port absent; every retire event attempts a push.

Test Plan:
- Reset then 3 retires: REG r3=0x0005 at PC 0x0000, STORE addr 0x0010 val 0xBEEF, branch at PC 0x0004; out_ready=1 -> records kinds 1,3,0 with inum 0,1,2, correct fields, each appearing 1 cycle after capture; inst_count=3.
- LOAD: regwrite=1, memread=1, wreg=2, wdata=0x1234, addr=0x0020 -> kind 2, out_reg=2, out_value=0x1234, out_addr=0x0020.
- out_ready=0, 10 consecutive retires with DEPTH=8 -> 8 buffered (inum 0-7), drop_count=2, overflow=1, inst_count=10; then raise out_ready -> inum 0..7 drained in order, data stable while stalled.
- Full FIFO, out_ready=1, push and pop in the same cycle -> no drop, occupancy stays 8.
- HALT retire with 3 records queued, out_ready toggling -> state DRAIN, later retires ignored (inst_count unchanged), halted=1 one cycle after the last pop, cycle_count frozen thereafter.
- Assert rst_n=0 in DRAIN with 4 records queued -> next cycle out_valid=0, all counters 0, halted=0; a new retire gets inum 0.

Source files
------------

// File: rtl/commit_monitor.sv
// commit_monitor: classifies retired instructions into a record FIFO, keeps counters, sequences halt.
// Optional macro TRACE_FILTER_EN adds filter_mask[4:0] to suppress pushes per kind.
module commit_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_pc,
  input  logic [15:0]      in_inst,
  input  logic             in_regwrite,
  input  logic [3:0]       in_wreg,
  input  logic [15:0]      in_wdata,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  logic [15:0]      in_memaddr,
  input  logic [15:0]      in_memdata,
  input  logic             in_halt,
`ifdef TRACE_FILTER_EN
  input  logic [4:0]       filter_mask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_kind,
  output logic [CNT_W-1:0] out_inum,
  output logic [15:0]      out_pc,
  output logic [3:0]       out_reg,
  output logic [15:0]      out_value,
  output logic [15:0]      out_addr,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  localparam logic [2:0] KOTHER = 3'd0;
  localparam logic [2:0] KREG = 3'd1;
  localparam logic [2:0] KLOAD = 3'd2;
  localparam logic [2:0] KSTORE = 3'd3;
  localparam logic [2:0] KHALT = 3'd4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [2:0]       kind;
    logic [CNT_W-1:0] inum;
    logic [15:0]      pc;
    logic [3:0]       rd;
    logic [15:0]      value;
    logic [15:0]      addr;
  } rec_t;

  state_t state, stateNext;
  rec_t mem [DEPTH];
  rec_t newRec, headRec;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic [CNT_W-1:0] instCount, cycleCount, dropCount;
  logic ovf;
  logic retire, empty, full, pop, push, keep, drop;
  logic unusedInst;

  assign unusedInst = ^in_inst;

  assign retire = in_valid & (state == RUN);
  assign empty = (count == '0);
  assign full = (count == FULL);
  assign out_valid = ~empty & (state != HALTED);
  assign pop = out_valid & out_ready;

`ifdef TRACE_FILTER_EN
  assign keep = filter_mask[newRec.kind];
`else
  assign keep = 1'b1;
`endif

  // a full FIFO still accepts when the head leaves this cycle
  assign push = retire & keep & (~full | pop);
  assign drop = retire & keep & full & ~pop;

  always_comb begin
    newRec = '0;
    newRec.inum = instCount;
    newRec.pc = in_pc;
    if (in_halt) begin
      newRec.kind = KHALT;
    end else if (in_regwrite & in_memread) begin
      newRec.kind = KLOAD;
      newRec.rd = in_wreg;
      newRec.value = in_wdata;
      newRec.addr = in_memaddr;
    end else if (in_regwrite) begin
      newRec.kind = KREG;
      newRec.rd = in_wreg;
      newRec.value = in_wdata;
    end else if (in_memwrite) begin
      newRec.kind = KSTORE;
      newRec.value = in_memdata;
      newRec.addr = in_memaddr;
    end else begin
      newRec.kind = KOTHER;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:
        if (retire & in_halt) stateNext = DRAIN;
      DRAIN:
        if (empty | ((count == ONE) & pop))
          stateNext = HALTED;
      HALTED:
        stateNext = HALTED;
      default:
        stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      instCount <= '0;
      cycleCount <= '0;
      dropCount <= '0;
      ovf <= 1'b0;
    end else begin
      state <= stateNext;
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (retire) instCount <= instCount + CNT_W'(1);
      if (state != HALTED)
        cycleCount <= cycleCount + CNT_W'(1);
      if (drop) begin
        dropCount <= dropCount + CNT_W'(1);
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newRec;
  end

  assign headRec = out_valid ? mem[rdPtr] : '0;

  assign out_kind = headRec.kind;
  assign out_inum = headRec.inum;
  assign out_pc = headRec.pc;
  assign out_reg = headRec.rd;
  assign out_value = headRec.value;
  assign out_addr = headRec.addr;

  assign inst_count = instCount;
  assign cycle_count = cycleCount;
  assign drop_count = dropCount;
  assign overflow = ovf;
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed and random stimulus against a queue-based model.
`timescale 1ns/1ps
module tb_commit_monitor;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_pc = '0;
  logic [15:0] in_inst = '0;
  logic in_regwrite = 1'b0;
  logic [3:0] in_wreg = '0;
  logic [15:0] in_wdata = '0;
  logic in_memread = 1'b0;
  logic in_memwrite = 1'b0;
  logic [15:0] in_memaddr = '0;
  logic [15:0] in_memdata = '0;
  logic in_halt = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [2:0] out_kind;
  logic [CNT_W-1:0] out_inum;
  logic [15:0] out_pc;
  logic [3:0] out_reg;
  logic [15:0] out_value;
  logic [15:0] out_addr;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] drop_count;
  logic overflow;
  logic halted;

  rec_t got;
  assign got = {out_kind, out_inum, out_pc, out_reg, out_value, out_addr};

  // reference model: spec-level queue, counters and run/drain/halted phase
  rec_t mq[$];
  logic [31:0] mInst, mCycle, mDrop;
  bit mOvf;
  int mState;
  int nChk = 0;
  int nErr = 0;

  commit_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_regwrite(in_regwrite), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_memaddr(in_memaddr), .in_memdata(in_memdata), .in_halt(in_halt),
`ifdef TRACE_FILTER_EN
    .filter_mask(5'h1f),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
    .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr),
    .inst_count(inst_count), .cycle_count(cycle_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic rec_t mkRec();
    rec_t r;
    r = '0;
    r.inum = mInst;
    r.pc = in_pc;
    if (in_halt) r.kind = 3'd4;
    else if (in_regwrite && in_memread) begin
      r.kind = 3'd2; r.rd = in_wreg; r.value = in_wdata; r.addr = in_memaddr;
    end else if (in_regwrite) begin
      r.kind = 3'd1; r.rd = in_wreg; r.value = in_wdata;
    end else if (in_memwrite) begin
      r.kind = 3'd3; r.value = in_memdata; r.addr = in_memaddr;
    end else r.kind = 3'd0;
    return r;
  endfunction

  function automatic rec_t expHead();
    rec_t r;
    r = '0;
    if (mq.size() > 0) r = mq[0];
    return r;
  endfunction

  function automatic bit expValid();
    return (mq.size() > 0) && (mState != 2);
  endfunction

  task automatic cycle();
    bit popF;
    bit ret;
    if (!rst_n) begin
      mq.delete();
      mInst = 0; mCycle = 0; mDrop = 0; mOvf = 0; mState = 0;
    end else begin
      popF = (mState != 2) && (mq.size() > 0) && out_ready;
      ret = in_valid && (mState == 0);
      if (mState != 2) mCycle++;
      if (popF) void'(mq.pop_front());
      if (ret) begin
        if (mq.size() < DEPTH) mq.push_back(mkRec());
        else begin mDrop++; mOvf = 1; end
        mInst++;
        if (in_halt) mState = 1;
      end else if (mState == 1 && mq.size() == 0) mState = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input bit rw, input bit mr, input bit mw,
                     input bit h, input logic [15:0] pc, input logic [3:0] wr,
                     input logic [15:0] wd, input logic [15:0] ma,
                     input logic [15:0] md);
    in_valid = v; in_regwrite = rw; in_memread = mr; in_memwrite = mw;
    in_halt = h; in_pc = pc; in_wreg = wr; in_wdata = wd;
    in_memaddr = ma; in_memdata = md; in_inst = 16'($urandom);
  endtask

  task automatic drv_rand(input bit v, input bit h);
    drv(v, 1'($urandom), 1'($urandom), 1'($urandom), h, 16'($urandom),
        4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv_rand(1, 0);
    out_ready = 1'b1;
    cycle();
    cycle();
    nChk++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    nChk++; if (got !== '0) begin nErr++; $display("FAIL reset_data got %h exp 0", got); end
    nChk++; if ({inst_count, cycle_count, drop_count} !== '0) begin nErr++; $display("FAIL reset_counters got %h %h %h exp 0", inst_count, cycle_count, drop_count); end
    nChk++; if ({overflow, halted} !== 2'b00) begin nErr++; $display("FAIL reset_flags got %b%b exp 00", overflow, halted); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    drv(1, 1, 0, 0, 0, 16'h0000, 4'd3, 16'h0005, 16'h7777, 16'h6666);
    cycle();
    nChk++; if ({out_valid, got} !== {1'b1, 3'd1, 32'd0, 16'h0000, 4'd3, 16'h0005, 16'h0000}) begin nErr++; $display("FAIL basic_reg got %b %h", out_valid, got); end
    drv(1, 0, 0, 1, 0, 16'h0002, 4'd9, 16'h1111, 16'h0010, 16'hBEEF);
    cycle();
    nChk++; if ({out_valid, got} !== {1'b1, 3'd3, 32'd1, 16'h0002, 4'd0, 16'hBEEF, 16'h0010}) begin nErr++; $display("FAIL basic_store got %b %h", out_valid, got); end
    drv(1, 0, 1, 0, 0, 16'h0004, 4'd7, 16'h2222, 16'h3333, 16'h4444);
    cycle();
    nChk++; if ({out_valid, got} !== {1'b1, 3'd0, 32'd2, 16'h0004, 4'd0, 16'h0000, 16'h0000}) begin nErr++; $display("FAIL basic_other got %b %h", out_valid, got); end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    nChk++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL basic_empty got %b exp 0", out_valid); end
    nChk++; if (inst_count !== 32'd3) begin nErr++; $display("FAIL basic_inst got %0d exp 3", inst_count); end
  endtask

  task automatic test_load();
    drv(1, 1, 1, 0, 0, 16'h0006, 4'd2, 16'h1234, 16'h0020, 16'h5555);
    cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nChk++; if ({out_valid, got} !== {1'b1, 3'd2, 32'd3, 16'h0006, 4'd2, 16'h1234, 16'h0020}) begin nErr++; $display("FAIL load_rec got %b %h", out_valid, got); end
    cycle();
  endtask

  task automatic test_overflow();
    rec_t held;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv_rand(1, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nChk++; if (inst_count !== 32'd10) begin nErr++; $display("FAIL ovf_inst got %0d exp 10", inst_count); end
    nChk++; if (drop_count !== 32'd2) begin nErr++; $display("FAIL ovf_drop got %0d exp 2", drop_count); end
    nChk++; if (overflow !== 1'b1) begin nErr++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    held = got;
    for (int i = 0; i < 3; i++) cycle();
    nChk++; if (got !== held || got !== expHead()) begin nErr++; $display("FAIL ovf_stall got %h exp %h", got, expHead()); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nChk++; if (out_valid !== 1'b1 || got.inum !== 32'(i) || got !== expHead()) begin nErr++; $display("FAIL ovf_drain%0d got %b %h exp %h", i, out_valid, got, expHead()); end
      cycle();
    end
    nChk++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL ovf_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full_pushpop();
    int n;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv_rand(1, 0);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_rand(1, 0);
      cycle();
      nChk++; if (drop_count !== 32'd0 || overflow !== 1'b0) begin nErr++; $display("FAIL full_pp%0d got drop %0d ovf %b exp 0 0", i, drop_count, overflow); end
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      nChk++; if (got !== expHead() || got.inum !== 32'(n + 3)) begin nErr++; $display("FAIL full_drain%0d got %h exp %h", n, got, expHead()); end
      n++;
      cycle();
    end
    nChk++; if (n !== 8) begin nErr++; $display("FAIL full_occupancy got %0d exp 8", n); end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    int k;
    do_reset();
    out_ready = 1'b0;
    drv(1, 1, 0, 0, 0, 16'h0010, 4'd1, 16'h00AA, 0, 0);
    cycle();
    drv(1, 0, 0, 1, 0, 16'h0012, 0, 0, 16'h0040, 16'h00BB);
    cycle();
    drv(1, 0, 0, 0, 1, 16'h0014, 0, 0, 0, 0);
    cycle();
    nChk++; if (halted !== 1'b0 || out_valid !== 1'b1) begin nErr++; $display("FAIL halt_drain got halted %b valid %b exp 0 1", halted, out_valid); end
    k = 0;
    while (mState != 2 && k < 40) begin
      drv_rand(1, 1'($urandom));
      out_ready = k[0];
      cycle();
      nChk++; if (inst_count !== 32'd3 || halted !== (mState == 2)) begin nErr++; $display("FAIL halt_step%0d got inst %0d halted %b exp 3 %b", k, inst_count, halted, mState == 2); end
      if (out_valid && got !== expHead()) begin nErr++; $display("FAIL halt_rec%0d got %h exp %h", k, got, expHead()); end
      k++;
    end
    nChk++; if (mState != 2) begin nErr++; $display("FAIL halt_timeout got state %0d exp 2", mState); end
    nChk++; if (cycle_count !== mCycle) begin nErr++; $display("FAIL halt_cycles got %0d exp %0d", cycle_count, mCycle); end
    c0 = mCycle;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_rand(1, 0);
      cycle();
    end
    nChk++; if (cycle_count !== c0 || inst_count !== 32'd3) begin nErr++; $display("FAIL halt_frozen got cyc %0d inst %0d exp %0d 3", cycle_count, inst_count, c0); end
    nChk++; if (out_valid !== 1'b0 || halted !== 1'b1) begin nErr++; $display("FAIL halt_final got valid %b halted %b exp 0 1", out_valid, halted); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_rand(1, 0);
      cycle();
    end
    drv(1, 0, 0, 0, 1, 16'h0100, 0, 0, 0, 0);
    cycle();
    nChk++; if (out_valid !== 1'b1 || halted !== 1'b0 || inst_count !== 32'd4) begin nErr++; $display("FAIL mid_pre got valid %b halted %b inst %0d exp 1 0 4", out_valid, halted, inst_count); end
    rst_n = 1'b0;
    drv_rand(1, 0);
    cycle();
    nChk++; if (out_valid !== 1'b0 || halted !== 1'b0) begin nErr++; $display("FAIL mid_flags got valid %b halted %b exp 0 0", out_valid, halted); end
    nChk++; if ({inst_count, cycle_count, drop_count, overflow} !== '0) begin nErr++; $display("FAIL mid_counters got %0d %0d %0d %b exp 0", inst_count, cycle_count, drop_count, overflow); end
    rst_n = 1'b1;
    drv(1, 1, 0, 0, 0, 16'h0200, 4'd5, 16'h0042, 0, 0);
    cycle();
    nChk++; if ({out_valid, got} !== {1'b1, 3'd1, 32'd0, 16'h0200, 4'd5, 16'h0042, 16'h0000}) begin nErr++; $display("FAIL mid_first got %b %h", out_valid, got); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drv_rand($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
      nChk++; if (out_valid !== expValid()) begin nErr++; $display("FAIL rnd_valid%0d got %b exp %b", i, out_valid, expValid()); end
      if (expValid()) begin
        nChk++; if (got !== expHead()) begin nErr++; $display("FAIL rnd_rec%0d got %h exp %h", i, got, expHead()); end
      end
      nChk++; if ({inst_count, cycle_count, drop_count} !== {mInst, mCycle, mDrop}) begin nErr++; $display("FAIL rnd_cnt%0d got %0d %0d %0d exp %0d %0d %0d", i, inst_count, cycle_count, drop_count, mInst, mCycle, mDrop); end
      nChk++; if ({overflow, halted} !== {mOvf, mState == 2}) begin nErr++; $display("FAIL rnd_flags%0d got %b%b exp %b%b", i, overflow, halted, mOvf, mState == 2); end
    end
  endtask

  initial begin
    mq.delete();
    mInst = 0; mCycle = 0; mDrop = 0; mOvf = 0; mState = 0;
    test_reset();
    test_basic();
    test_load();
    test_overflow();
    test_full_pushpop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nErr);
    $finish;
  end

endmodule
